cmd_ctrl: RTL and testbench

//  Command controller between the UART receiver/transmitter and the register file / ALU.

---
 rtl/cmd_ctrl.sv | 160 ++++++++++++++++
 tb/tb_cmd_ctrl.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_ctrl.sv
// Byte-command controller: parses UART RX commands into register file strobes and ALU
// triggers, and returns read data / ALU results to UART TX over a valid/busy handshake.
module cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     rx_data,
  input  logic                      rx_valid,
  input  logic [DATA_WIDTH-1:0]     reg_rd_data,
  input  logic                      reg_rd_valid,
  input  logic [2*DATA_WIDTH-1:0]   alu_out,
  input  logic                      alu_out_valid,
  input  logic                      tx_busy,
  output logic [ADDR_WIDTH-1:0]     reg_addr,
  output logic [DATA_WIDTH-1:0]     reg_wr_data,
  output logic                      reg_wr_en,
  output logic                      reg_rd_en,
  output logic                      alu_en,
  output logic [3:0]                alu_fun,
  output logic [DATA_WIDTH-1:0]     tx_data,
  output logic                      tx_valid
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] WR_ADDR  = 4'd1;
  localparam logic [3:0] WR_DATA  = 4'd2;
  localparam logic [3:0] RD_ADDR  = 4'd3;
  localparam logic [3:0] RD_WAIT  = 4'd4;
  localparam logic [3:0] ALU_A    = 4'd5;
  localparam logic [3:0] ALU_B    = 4'd6;
  localparam logic [3:0] ALU_FUN  = 4'd7;
  localparam logic [3:0] ALU_WAIT = 4'd8;
  localparam logic [3:0] TX_LO    = 4'd9;
  localparam logic [3:0] TX_HI    = 4'd10;

  localparam logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OPS = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU     = DATA_WIDTH'(8'hDD);

  logic [3:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] result_hi;
  logic                  is_alu;

  // The low result byte goes straight into tx_data on capture; only the high byte is kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      addr        <= '0;
      result_hi   <= '0;
      is_alu      <= 1'b0;
      reg_addr    <= '0;
      reg_wr_data <= '0;
      reg_wr_en   <= 1'b0;
      reg_rd_en   <= 1'b0;
      alu_en      <= 1'b0;
      alu_fun     <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            if (rx_data == CMD_WR)           state <= WR_ADDR;
            else if (rx_data == CMD_RD)      state <= RD_ADDR;
            else if (rx_data == CMD_ALU_OPS) state <= ALU_A;
            else if (rx_data == CMD_ALU)     state <= ALU_FUN;
          end
        end
        WR_ADDR: begin
          if (rx_valid) begin
            addr  <= rx_data[ADDR_WIDTH-1:0];
            state <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (rx_valid) begin
            reg_addr    <= addr;
            reg_wr_data <= rx_data;
            reg_wr_en   <= 1'b1;
            state       <= IDLE;
          end
        end
        RD_ADDR: begin
          if (rx_valid) begin
            reg_addr  <= rx_data[ADDR_WIDTH-1:0];
            reg_rd_en <= 1'b1;
            state     <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (reg_rd_valid) begin
            result_hi <= '0;
            is_alu    <= 1'b0;
            tx_data   <= reg_rd_data;
            tx_valid  <= 1'b1;
            state     <= TX_LO;
          end
        end
        ALU_A: begin
          if (rx_valid) begin
            reg_addr    <= '0;
            reg_wr_data <= rx_data;
            reg_wr_en   <= 1'b1;
            state       <= ALU_B;
          end
        end
        ALU_B: begin
          if (rx_valid) begin
            reg_addr    <= ADDR_WIDTH'(1);
            reg_wr_data <= rx_data;
            reg_wr_en   <= 1'b1;
            state       <= ALU_FUN;
          end
        end
        ALU_FUN: begin
          if (rx_valid) begin
            alu_fun <= rx_data[3:0];
            alu_en  <= 1'b1;
            state   <= ALU_WAIT;
          end
        end
        ALU_WAIT: begin
          if (alu_out_valid) begin
            alu_en    <= 1'b0;
            result_hi <= alu_out[2*DATA_WIDTH-1:DATA_WIDTH];
            is_alu    <= 1'b1;
            tx_data   <= alu_out[DATA_WIDTH-1:0];
            tx_valid  <= 1'b1;
            state     <= TX_LO;
          end
        end
        TX_LO: begin
          if (!tx_busy) begin
            if (is_alu) begin
              tx_data <= result_hi;
              state   <= TX_HI;
            end else begin
              tx_valid <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        TX_HI: begin
          if (!tx_busy) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_ctrl.sv
// Testbench for cmd_ctrl: register file / ALU / UART TX stand-ins plus a command-level model.
module tb_cmd_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  reg_rd_data = '0;
  logic        reg_rd_valid = 1'b0;
  logic [15:0] alu_out = '0;
  logic        alu_out_valid = 1'b0;
  logic        tx_busy = 1'b0;
  logic [3:0]  reg_addr;
  logic [7:0]  reg_wr_data;
  logic        reg_wr_en, reg_rd_en, alu_en, tx_valid;
  logic [3:0]  alu_fun;
  logic [7:0]  tx_data;

  cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .reg_rd_data(reg_rd_data), .reg_rd_valid(reg_rd_valid),
    .alu_out(alu_out), .alu_out_valid(alu_out_valid), .tx_busy(tx_busy),
    .reg_addr(reg_addr), .reg_wr_data(reg_wr_data), .reg_wr_en(reg_wr_en),
    .reg_rd_en(reg_rd_en), .alu_en(alu_en), .alu_fun(alu_fun),
    .tx_data(tx_data), .tx_valid(tx_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int alu_lat = 3;
  int alu_cnt = 0;
  int busy_mode = 0;
  logic [7:0]  mem [16];
  logic [7:0]  exp_mem [16];
  logic [11:0] wr_q [$];
  logic [3:0]  rd_q [$];
  logic [7:0]  tx_q [$];
  logic [11:0] e_wr [$];
  logic [3:0]  e_rd [$];
  logic [7:0]  e_tx [$];
  logic        prev_hold = 1'b0;
  logic [7:0]  prev_data = '0;

  // Stand-in ALU: an arbitrary but fixed function of the two operand registers.
  function automatic logic [15:0] calc(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    case (f[1:0])
      2'd0:    return 16'(a) + 16'(b);
      2'd1:    return 16'(a) - 16'(b);
      2'd2:    return 16'(a) * 16'(b);
      default: return {a, b};
    endcase
  endfunction

  // Register file and ALU responders
  always @(posedge clk) begin
    if (reg_wr_en) mem[reg_addr] <= reg_wr_data;
    reg_rd_valid <= reg_rd_en;
    reg_rd_data  <= mem[reg_addr];
    if (!alu_en) begin
      alu_cnt <= 0;
      alu_out_valid <= 1'b0;
    end else if (alu_out_valid) begin
      alu_out_valid <= 1'b0;
    end else if (alu_cnt + 1 >= alu_lat) begin
      alu_out_valid <= 1'b1;
      alu_out <= calc(mem[0], mem[1], alu_fun);
    end else begin
      alu_cnt <= alu_cnt + 1;
    end
  end

  always @(posedge clk) begin
    #2;
    case (busy_mode)
      0:       tx_busy = 1'b0;
      1:       tx_busy = 1'b1;
      default: tx_busy = 1'($urandom_range(0, 1));
    endcase
  end

  // Activity monitor with always-on protocol checks
  always @(negedge clk) begin
    if (reset) begin
      if (reg_wr_en) wr_q.push_back({reg_addr, reg_wr_data});
      if (reg_rd_en) rd_q.push_back(reg_addr);
      if (tx_valid && !tx_busy) tx_q.push_back(tx_data);
      n_checks++;
      if ((reg_wr_en && reg_rd_en) || (reg_wr_en && alu_en)) begin
        n_fail++;
        $display("FAIL strobe_excl: wr_en=%0b rd_en=%0b alu_en=%0b, required no overlap", reg_wr_en, reg_rd_en, alu_en);
      end
      if (prev_hold) begin
        n_checks++;
        if (!tx_valid || tx_data !== prev_data) begin
          n_fail++;
          $display("FAIL tx_hold: valid=%0b data=%h, required valid=1 data=%h", tx_valid, tx_data, prev_data);
        end
      end
      prev_hold = tx_valid && tx_busy;
      prev_data = tx_data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_q();
    wr_q.delete(); rd_q.delete(); tx_q.delete();
    e_wr.delete(); e_rd.delete(); e_tx.delete();
  endtask

  task automatic wait_tx(input int n);
    int k = 0;
    while (tx_q.size() < n && k < 400) begin
      @(negedge clk);
      k++;
    end
  endtask

  // Command-level model: records expected activity and returns the command length in bytes.
  function automatic int expect_cmd(input logic [7:0] op, input logic [7:0] b1,
                                    input logic [7:0] b2, input logic [7:0] b3);
    logic [15:0] r;
    case (op)
      8'hAA: begin
        e_wr.push_back({b1[3:0], b2});
        exp_mem[b1[3:0]] = b2;
        return 3;
      end
      8'hBB: begin
        e_rd.push_back(b1[3:0]);
        e_tx.push_back(exp_mem[b1[3:0]]);
        return 2;
      end
      8'hCC: begin
        e_wr.push_back({4'd0, b1});
        e_wr.push_back({4'd1, b2});
        exp_mem[0] = b1;
        exp_mem[1] = b2;
        r = calc(b1, b2, b3[3:0]);
        e_tx.push_back(r[7:0]);
        e_tx.push_back(r[15:8]);
        return 4;
      end
      8'hDD: begin
        r = calc(exp_mem[0], exp_mem[1], b1[3:0]);
        e_tx.push_back(r[7:0]);
        e_tx.push_back(r[15:8]);
        return 2;
      end
      default: return 1;
    endcase
  endfunction

  task automatic run_cmd(input logic [7:0] op, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
    int n;
    clear_q();
    n = expect_cmd(op, b1, b2, b3);
    send_byte(op);
    if (n > 1) send_byte(b1);
    if (n > 2) send_byte(b2);
    if (n > 3) send_byte(b3);
    wait_tx(e_tx.size());
    idle(4);
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    idle(3);
    n_checks++;
    if ({reg_addr, reg_wr_data, reg_wr_en, reg_rd_en, alu_en, alu_fun, tx_data, tx_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: addr=%h wd=%h we=%0b re=%0b ae=%0b fun=%h txd=%h txv=%0b, required all 0",
               reg_addr, reg_wr_data, reg_wr_en, reg_rd_en, alu_en, alu_fun, tx_data, tx_valid);
    end
    reset = 1'b1;
    idle(2);
  endtask

  task automatic test_write();
    int n;
    clear_q();
    n = expect_cmd(8'hAA, 8'h05, 8'h3C, 8'h00);
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    n_checks++;
    if (reg_wr_en !== 1'b1 || reg_addr !== 4'h5 || reg_wr_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL write_strobe: we=%0b addr=%h data=%h, required we=1 addr=5 data=3c", reg_wr_en, reg_addr, reg_wr_data);
    end
    idle(1);
    n_checks++;
    if (reg_wr_en !== 1'b0 || wr_q.size() != 1) begin
      n_fail++;
      $display("FAIL write_pulse: we=%0b writes=%0d, required we=0 writes=1", reg_wr_en, wr_q.size());
    end
    idle(2);
  endtask

  task automatic test_read();
    int n;
    run_cmd(8'hAA, 8'h02, 8'h81, 8'h00);
    clear_q();
    busy_mode = 1;
    n = expect_cmd(8'hBB, 8'h02, 8'h00, 8'h00);
    send_byte(8'hBB); send_byte(8'h02);
    n_checks++;
    if (reg_rd_en !== 1'b1 || reg_addr !== 4'h2) begin
      n_fail++;
      $display("FAIL read_strobe: re=%0b addr=%h, required re=1 addr=2", reg_rd_en, reg_addr);
    end
    idle(3);
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h81 || tx_q.size() != 0) begin
      n_fail++;
      $display("FAIL read_present: txv=%0b txd=%h sent=%0d, required txv=1 txd=81 sent=0", tx_valid, tx_data, tx_q.size());
    end
    busy_mode = 0;
    wait_tx(1);
    idle(5);
    n_checks++;
    if (tx_q.size() != 1 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL read_count: sent=%0d txv=%0b, required sent=1 txv=0", tx_q.size(), tx_valid);
    end else begin
      n_checks++;
      if (tx_q[0] !== 8'h81) begin
        n_fail++;
        $display("FAIL read_byte: got %h, required 81", tx_q[0]);
      end
    end
  endtask

  task automatic test_alu();
    int n;
    clear_q();
    alu_lat = 3;
    n = expect_cmd(8'hCC, 8'h07, 8'h03, 8'h02);
    send_byte(8'hCC); send_byte(8'h07); send_byte(8'h03); send_byte(8'h02);
    n_checks++;
    if (wr_q.size() != 2 || alu_en !== 1'b1 || alu_fun !== 4'h2) begin
      n_fail++;
      $display("FAIL alu_start: writes=%0d alu_en=%0b fun=%h, required writes=2 alu_en=1 fun=2", wr_q.size(), alu_en, alu_fun);
    end else begin
      n_checks++;
      if (wr_q[0] !== 12'h007 || wr_q[1] !== 12'h103) begin
        n_fail++;
        $display("FAIL alu_operands: got %h %h, required 007 103", wr_q[0], wr_q[1]);
      end
    end
    wait_tx(2);
    idle(4);
    n_checks++;
    if (tx_q.size() != 2) begin
      n_fail++;
      $display("FAIL alu_tx_count: sent=%0d, required 2", tx_q.size());
    end else begin
      n_checks++;
      if (tx_q[0] !== 8'h15 || tx_q[1] !== 8'h00) begin
        n_fail++;
        $display("FAIL alu_tx_bytes: got %h %h, required 15 00", tx_q[0], tx_q[1]);
      end
    end
    n_checks++;
    if (alu_en !== 1'b0 || alu_fun !== 4'h2 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_done: alu_en=%0b fun=%h txv=%0b, required 0 2 0", alu_en, alu_fun, tx_valid);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int bad = 0;
    logic [7:0] d;
    clear_q();
    busy_mode = 1;
    n = expect_cmd(8'hBB, 8'h05, 8'h00, 8'h00);
    send_byte(8'hBB); send_byte(8'h05);
    idle(3);
    d = tx_data;
    repeat (20) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== d || tx_q.size() != 0) bad++;
    end
    n_checks++;
    if (bad != 0 || d !== e_tx[0]) begin
      n_fail++;
      $display("FAIL busy_hold: bad_cycles=%0d data=%h, required 0 and %h", bad, d, e_tx[0]);
    end
    busy_mode = 0;
    wait_tx(1);
    idle(3);
    n_checks++;
    if (tx_q.size() != 1 || tx_q[0] !== e_tx[0]) begin
      n_fail++;
      $display("FAIL busy_release: sent=%0d, required 1 byte %h", tx_q.size(), e_tx[0]);
    end
  endtask

  task automatic test_ignored_bytes();
    int n;
    clear_q();
    send_byte(8'h11);
    idle(3);
    n_checks++;
    if (wr_q.size() != 0 || rd_q.size() != 0 || tx_q.size() != 0 || alu_en !== 1'b0) begin
      n_fail++;
      $display("FAIL junk_idle: writes=%0d reads=%0d sent=%0d alu_en=%0b, required all 0", wr_q.size(), rd_q.size(), tx_q.size(), alu_en);
    end
    alu_lat = 20;
    n = expect_cmd(8'hDD, 8'h00, 8'h00, 8'h00);
    send_byte(8'hDD); send_byte(8'h00);
    idle(2);
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    wait_tx(2);
    idle(4);
    n_checks++;
    if (wr_q.size() != 0 || tx_q.size() != 2) begin
      n_fail++;
      $display("FAIL alu_wait_drop: writes=%0d sent=%0d, required 0 and 2", wr_q.size(), tx_q.size());
    end else begin
      n_checks++;
      if (tx_q[0] !== e_tx[0] || tx_q[1] !== e_tx[1]) begin
        n_fail++;
        $display("FAIL alu_wait_result: got %h %h, required %h %h", tx_q[0], tx_q[1], e_tx[0], e_tx[1]);
      end
    end
    alu_lat = 3;
    run_cmd(8'hAA, 8'h09, 8'h5A, 8'h00);
    n_checks++;
    if (wr_q.size() != 1 || wr_q[0] !== 12'h95A) begin
      n_fail++;
      $display("FAIL after_drop_write: writes=%0d, required one write 95a", wr_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_q();
    send_byte(8'hAA); send_byte(8'h05);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({reg_addr, reg_wr_data, reg_wr_en, reg_rd_en, alu_en, alu_fun, tx_data, tx_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: addr=%h wd=%h we=%0b re=%0b ae=%0b fun=%h txd=%h txv=%0b, required all 0",
               reg_addr, reg_wr_data, reg_wr_en, reg_rd_en, alu_en, alu_fun, tx_data, tx_valid);
    end
    idle(2);
    reset = 1'b1;
    idle(1);
    n = expect_cmd(8'hBB, 8'h00, 8'h00, 8'h00);
    send_byte(8'hBB); send_byte(8'h00);
    n_checks++;
    if (reg_rd_en !== 1'b1 || reg_addr !== 4'h0 || reg_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_read: re=%0b we=%0b addr=%h, required re=1 we=0 addr=0", reg_rd_en, reg_wr_en, reg_addr);
    end
    wait_tx(1);
    idle(4);
    n_checks++;
    if (tx_q.size() != 1 || tx_q[0] !== e_tx[0] || wr_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_tx: sent=%0d writes=%0d, required one byte %h and no writes", tx_q.size(), wr_q.size(), e_tx[0]);
    end
  endtask

  task automatic test_random();
    logic [7:0] op;
    busy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: op = 8'hAA;
        1: op = 8'hBB;
        2: op = 8'hCC;
        3: op = 8'hDD;
        default: begin
          op = 8'($urandom);
          if (op == 8'hAA || op == 8'hBB || op == 8'hCC || op == 8'hDD) op = 8'h00;
        end
      endcase
      alu_lat = $urandom_range(1, 6);
      run_cmd(op, 8'($urandom), 8'($urandom), 8'($urandom));
      n_checks++;
      if (wr_q != e_wr || rd_q != e_rd || tx_q != e_tx) begin
        n_fail++;
        $display("FAIL random_cmd%0d op=%h: writes=%0d/%0d reads=%0d/%0d tx=%0d/%0d (got/required)",
                 i, op, wr_q.size(), e_wr.size(), rd_q.size(), e_rd.size(), tx_q.size(), e_tx.size());
      end
    end
    busy_mode = 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = '0;
      exp_mem[i] = '0;
    end
    test_reset();
    test_write();
    test_read();
    test_alu();
    test_backpressure();
    test_ignored_bytes();
    test_reset_mid();
    test_random();
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
